// File: rtl/ps2_pkg.sv
// ps2_pkg
//   Shared definitions for the PS/2 key-event engine: scan-code prefix
//   bytes, the set of controller/status bytes that never form key events,
//   the parser state encoding and the packed event record that travels
//   through the event FIFO.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;  // extended-key prefix
    localparam logic [7:0] PS2_BRK = 8'hF0;  // release prefix

    // Controller / status bytes that carry no key information.
    localparam logic [7:0] PS2_ERR0   = 8'h00;  // key detection error
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;  // self-test passed
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;  // pause-key prefix
    localparam logic [7:0] PS2_ECHO   = 8'hEE;  // echo response
    localparam logic [7:0] PS2_ACK    = 8'hFA;  // command acknowledge
    localparam logic [7:0] PS2_RESEND = 8'hFE;  // resend request
    localparam logic [7:0] PS2_ERR1   = 8'hFF;  // key detection error

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } parser_state_e;

    // Event record as stored in the FIFO: {ext, brk, code}.
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    localparam int EVT_W = $bits(ps2_evt_t);

    function automatic logic is_ignored(input logic [7:0] b);
        return (b == PS2_ERR0)   || (b == PS2_BAT_OK) || (b == PS2_PAUSE) ||
               (b == PS2_ECHO)   || (b == PS2_ACK)    || (b == PS2_RESEND) ||
               (b == PS2_ERR1);
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo
//   Synchronous FIFO with registered storage and a first-word fall-through
//   head: the oldest entry is visible on head_o whenever empty_o is low.
//   Handshake: a pop happens on a cycle where pop_i=1 and the FIFO is
//   non-empty; a push is accepted when not full, or when full and a pop
//   happens in the same cycle. A push while full without a pop is dropped.
//   Ports:
//     clk, resetn     clock, synchronous active-low reset
//     push_i, data_i  write request and entry
//     pop_i           consumer takes the head entry
//     head_o          head entry (zero while empty)
//     empty_o/full_o  occupancy flags
//     level_o         entries held, 0..DEPTH
module ps2_evt_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q,  level_d;
    logic             do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign level_o = level_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    // Full plus a simultaneous pop frees the slot being written.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: nothing is read until a push has written it.
    always_ff @(posedge clk) begin
        if (resetn && do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
//   Turns the received PS/2 scan-code byte stream into make/break key
//   events (E0-extended keys included), filters typematic repeats, tracks
//   the currently held key, counts new presses and queues events in a FIFO.
//   Drain handshake: evt_valid=1 presents the head event; it is consumed on
//   any cycle with evt_valid && evt_ready, and held stable otherwise.
//   Ports:
//     clk, resetn                    clock, synchronous active-low reset
//     byte_valid, byte_data          received byte strobe and value
//     evt_ready                      consumer takes the head event
//     evt_valid/code/ext/break       head event
//     fifo_level                     entries held
//     overflow                       sticky: an event was dropped (FIFO full)
//     key_down, cur_code, cur_ext    held-key tracking
//     press_cnt                      new (non-repeat) make count, wrapping
//     dbg_state                      parser state (ps2_pkg::parser_state_e)
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 8,
    parameter bit REPEAT_EVT = 1'b0
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        byte_valid,
    input  logic [7:0]                  byte_data,
    input  logic                        evt_ready,
    output logic                        evt_valid,
    output logic [7:0]                  evt_code,
    output logic                        evt_ext,
    output logic                        evt_break,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    output logic                        key_down,
    output logic [7:0]                  cur_code,
    output logic                        cur_ext,
    output logic [CNT_W-1:0]            press_cnt,
    output logic [1:0]                  dbg_state
);

    // ---------------- parser FSM ----------------
    parser_state_e state_q, state_d;
    logic          raw_vld;
    ps2_evt_t      raw_evt;
    logic          is_prefix;

    assign is_prefix = (byte_data == PS2_EXT) || (byte_data == PS2_BRK);

    always_ff @(posedge clk) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (byte_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (byte_data == PS2_EXT)      state_d = ST_EXT;
                    else if (byte_data == PS2_BRK) state_d = ST_BRK;
                    else                           state_d = ST_IDLE;
                end
                ST_EXT: begin
                    if (byte_data == PS2_BRK)      state_d = ST_EXT_BRK;
                    else if (byte_data == PS2_EXT) state_d = ST_EXT;
                    else                           state_d = ST_IDLE;
                end
                // A code byte completes the break; a prefix here is a
                // protocol error. Either way the sequence ends.
                ST_BRK, ST_EXT_BRK: state_d = ST_IDLE;
                default:            state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        raw_vld      = 1'b0;
        raw_evt      = '0;
        raw_evt.code = byte_data;
        if (byte_valid && !is_prefix) begin
            case (state_q)
                ST_IDLE: raw_vld = !is_ignored(byte_data);
                ST_EXT: begin
                    raw_vld     = 1'b1;
                    raw_evt.ext = 1'b1;
                end
                ST_BRK: begin
                    raw_vld     = 1'b1;
                    raw_evt.brk = 1'b1;
                end
                ST_EXT_BRK: begin
                    raw_vld     = 1'b1;
                    raw_evt.ext = 1'b1;
                    raw_evt.brk = 1'b1;
                end
                default: raw_vld = 1'b0;
            endcase
        end
    end

    assign dbg_state = state_q;

    // ---------------- event stage ----------------
    // One register between parser and tracking: the event lands in the
    // FIFO and the tracking state updates one edge after the final byte.
    logic     pend_vld_q;
    ps2_evt_t pend_evt_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pend_vld_q <= 1'b0;
            pend_evt_q <= '0;
        end else begin
            pend_vld_q <= raw_vld;
            pend_evt_q <= raw_evt;
        end
    end

    // ---------------- repeat filter / tracking ----------------
    logic             key_down_q, key_down_d;
    logic [7:0]       cur_code_q, cur_code_d;
    logic             cur_ext_q,  cur_ext_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic             overflow_q, overflow_d;
    logic             held_match, is_repeat, fifo_push;
    logic             fifo_empty, fifo_full;
    logic [EVT_W-1:0] fifo_head;
    ps2_evt_t         head_evt;

    assign held_match = (pend_evt_q.code == cur_code_q) && (pend_evt_q.ext == cur_ext_q);
    assign is_repeat  = !pend_evt_q.brk && key_down_q && held_match;
    assign fifo_push  = pend_vld_q && (pend_evt_q.brk || !is_repeat || REPEAT_EVT);

    always_comb begin
        key_down_d  = key_down_q;
        cur_code_d  = cur_code_q;
        cur_ext_d   = cur_ext_q;
        press_cnt_d = press_cnt_q;
        // When full, evt_valid is 1, so evt_ready alone decides the pop.
        overflow_d  = overflow_q | (fifo_push && fifo_full && !evt_ready);
        if (pend_vld_q) begin
            if (pend_evt_q.brk) begin
                if (held_match) key_down_d = 1'b0;
            end else if (!is_repeat) begin
                key_down_d  = 1'b1;
                cur_code_d  = pend_evt_q.code;
                cur_ext_d   = pend_evt_q.ext;
                press_cnt_d = press_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            key_down_q  <= 1'b0;
            cur_code_q  <= '0;
            cur_ext_q   <= 1'b0;
            press_cnt_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            key_down_q  <= key_down_d;
            cur_code_q  <= cur_code_d;
            cur_ext_q   <= cur_ext_d;
            press_cnt_q <= press_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    // ---------------- event FIFO ----------------
    ps2_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (fifo_push),
        .data_i  (pend_evt_q),
        .pop_i   (evt_ready),
        .head_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .level_o (fifo_level)
    );

    assign head_evt  = fifo_head;
    assign evt_valid = !fifo_empty;
    assign evt_code  = head_evt.code;
    assign evt_ext   = head_evt.ext;
    assign evt_break = head_evt.brk;

    assign overflow  = overflow_q;
    assign key_down  = key_down_q;
    assign cur_code  = cur_code_q;
    assign cur_ext   = cur_ext_q;
    assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
module tb_ps2_key_tracker;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic       byte_valid = 1'b0;
    logic [7:0] byte_data  = 8'h00;
    logic       evt_ready  = 1'b0;

    // dut0: defaults; dut1: REPEAT_EVT=1; dut2: CNT_W=4
    logic       v0, x0, b0, ov0, kd0, ce0;
    logic [7:0] c0, cc0, pc0;
    logic [3:0] lvl0;
    logic [1:0] st0;

    logic       v1, x1, b1, ov1, kd1, ce1;
    logic [7:0] c1, cc1, pc1;
    logic [3:0] lvl1;
    logic [1:0] st1;

    logic       v2, x2, b2, ov2, kd2, ce2;
    logic [7:0] c2, cc2;
    logic [3:0] pc2;
    logic [3:0] lvl2;
    logic [1:0] st2;

    ps2_key_tracker #(.FIFO_DEPTH(8), .CNT_W(8), .REPEAT_EVT(1'b0)) dut0 (
        .clk(clk), .resetn(resetn), .byte_valid(byte_valid), .byte_data(byte_data),
        .evt_ready(evt_ready), .evt_valid(v0), .evt_code(c0), .evt_ext(x0),
        .evt_break(b0), .fifo_level(lvl0), .overflow(ov0), .key_down(kd0),
        .cur_code(cc0), .cur_ext(ce0), .press_cnt(pc0), .dbg_state(st0));

    ps2_key_tracker #(.FIFO_DEPTH(8), .CNT_W(8), .REPEAT_EVT(1'b1)) dut1 (
        .clk(clk), .resetn(resetn), .byte_valid(byte_valid), .byte_data(byte_data),
        .evt_ready(evt_ready), .evt_valid(v1), .evt_code(c1), .evt_ext(x1),
        .evt_break(b1), .fifo_level(lvl1), .overflow(ov1), .key_down(kd1),
        .cur_code(cc1), .cur_ext(ce1), .press_cnt(pc1), .dbg_state(st1));

    ps2_key_tracker #(.FIFO_DEPTH(8), .CNT_W(4), .REPEAT_EVT(1'b0)) dut2 (
        .clk(clk), .resetn(resetn), .byte_valid(byte_valid), .byte_data(byte_data),
        .evt_ready(evt_ready), .evt_valid(v2), .evt_code(c2), .evt_ext(x2),
        .evt_break(b2), .fifo_level(lvl2), .overflow(ov2), .key_down(kd2),
        .cur_code(cc2), .cur_ext(ce2), .press_cnt(pc2), .dbg_state(st2));

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    endtask

    // ---------------- scoreboard ----------------
    // Event record {ext, brk, code}
    logic [9:0] exp_q0[$];
    logic [9:0] exp_q1[$];
    logic       mon1_en = 1'b0;

    // Inputs change just after posedge, so at negedge these are the values
    // the next posedge will see: valid && ready here means a pop follows.
    always @(negedge clk) begin
        if (resetn && v0 && evt_ready) begin
            check("dut0_evt_expected", 32'(exp_q0.size() != 0), 32'd1);
            if (exp_q0.size() != 0) check("dut0_evt", {x0, b0, c0}, exp_q0.pop_front());
        end
        if (mon1_en && resetn && v1 && evt_ready) begin
            check("dut1_evt_expected", 32'(exp_q1.size() != 0), 32'd1);
            if (exp_q1.size() != 0) check("dut1_evt", {x1, b1, c1}, exp_q1.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge clk); #1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        resetn = 1'b0;
        byte_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn = 1'b1;
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && (exp_q0.size() != 0 || exp_q1.size() != 0); i++)
            @(posedge clk);
        repeat (3) @(posedge clk);
        check({tag, "_q0_left"}, exp_q0.size(), 0);
        check({tag, "_q1_left"}, exp_q1.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        do_reset();
        @(negedge clk);
        check("rst_evt_valid", v0, 0);
        check("rst_evt_code", c0, 0);
        check("rst_evt_ext", x0, 0);
        check("rst_evt_break", b0, 0);
        check("rst_level", lvl0, 0);
        check("rst_overflow", ov0, 0);
        check("rst_key_down", kd0, 0);
        check("rst_cur_code", cc0, 0);
        check("rst_cur_ext", ce0, 0);
        check("rst_press_cnt", pc0, 0);
        check("rst_state", st0, 0);

        // T1: 1C, F0 1C
        evt_ready = 1'b1;
        exp_q0.push_back({1'b0, 1'b0, 8'h1C});
        exp_q0.push_back({1'b0, 1'b1, 8'h1C});
        send(8'h1C);
        repeat (2) @(negedge clk);
        check("t1_key_down_make", kd0, 1);
        check("t1_cur_code_make", cc0, 8'h1C);
        check("t1_press_cnt_make", pc0, 1);
        send(8'hF0); send(8'h1C);
        repeat (2) @(negedge clk);
        check("t1_key_down_brk", kd0, 0);
        check("t1_cur_code_brk", cc0, 8'h1C);
        check("t1_press_cnt_brk", pc0, 1);
        drain("t1");

        // T2: E0 75, E0 F0 75
        do_reset();
        evt_ready = 1'b1;
        exp_q0.push_back({1'b1, 1'b0, 8'h75});
        exp_q0.push_back({1'b1, 1'b1, 8'h75});
        send(8'hE0); send(8'h75);
        repeat (2) @(negedge clk);
        check("t2_cur_ext", ce0, 1);
        check("t2_key_down_make", kd0, 1);
        send(8'hE0); send(8'hF0); send(8'h75);
        repeat (2) @(negedge clk);
        check("t2_key_down_brk", kd0, 0);
        check("t2_cur_ext_brk", ce0, 1);
        check("t2_press_cnt", pc0, 1);
        check("t2_state", st0, 0);
        drain("t2");

        // T3: 1C x5, F0 1C; dut0 drops repeats, dut1 keeps them
        do_reset();
        evt_ready = 1'b1;
        mon1_en = 1'b1;
        exp_q0.push_back({1'b0, 1'b0, 8'h1C});
        exp_q0.push_back({1'b0, 1'b1, 8'h1C});
        for (int i = 0; i < 5; i++) exp_q1.push_back({1'b0, 1'b0, 8'h1C});
        exp_q1.push_back({1'b0, 1'b1, 8'h1C});
        for (int i = 0; i < 5; i++) send(8'h1C);
        send(8'hF0); send(8'h1C);
        drain("t3");
        check("t3_press_cnt_r0", pc0, 1);
        check("t3_press_cnt_r1", pc1, 1);
        mon1_en = 1'b0;

        // T4: stall, 9 distinct makes -> full, overflow, drain first 8
        do_reset();
        evt_ready = 1'b0;
        begin
            logic [7:0] codes [9];
            codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
            send(codes[0]);
            @(negedge clk);
            check("t4_valid_before_n1", v0, 0);
            @(negedge clk);
            check("t4_valid_at_n1", v0, 1);
            check("t4_first_code", c0, 8'h15);
            for (int i = 1; i < 9; i++) send(codes[i]);
            repeat (3) @(negedge clk);
            check("t4_level_full", lvl0, 8);
            check("t4_overflow", ov0, 1);
            check("t4_press_cnt", pc0, 9);
            check("t4_cur_code", cc0, 8'h44);
            check("t4_head_stalled_a", c0, 8'h15);
            repeat (3) @(negedge clk);
            check("t4_head_stalled_b", c0, 8'h15);
            check("t4_valid_stalled", v0, 1);
            for (int i = 0; i < 8; i++) exp_q0.push_back({1'b0, 1'b0, codes[i]});
        end
        @(posedge clk); #1;
        evt_ready = 1'b1;
        drain("t4");
        @(negedge clk);
        check("t4_level_empty", lvl0, 0);
        check("t4_overflow_sticky", ov0, 1);
        check("t4_valid_empty", v0, 0);

        // T5: 17 press/release pairs with AA/FA noise; dut2 counter wraps
        do_reset();
        evt_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            logic [7:0] k;
            k = 8'h10 + 8'(i);
            exp_q0.push_back({1'b0, 1'b0, k});
            exp_q0.push_back({1'b0, 1'b1, k});
            send(8'hAA); send(k); send(8'hFA); send(8'hF0); send(k);
        end
        drain("t5");
        check("t5_press_cnt_w8", pc0, 17);
        check("t5_press_cnt_w4", pc2, 1);
        check("t5_key_down", kd2, 0);
        check("t5_overflow", ov0, 0);

        // T6: reset in the middle of E0 F0 <code>
        do_reset();
        evt_ready = 1'b1;
        send(8'hE0); send(8'hF0);
        @(negedge clk);
        check("t6_state_ext_brk", st0, 3);
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        check("t6_state_after_rst", st0, 0);
        exp_q0.push_back({1'b0, 1'b0, 8'h1C});
        send(8'h1C);
        drain("t6");
        check("t6_press_cnt", pc0, 1);
        check("t6_overflow", ov0, 0);
        check("t6_cur_ext", ce0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
